nibble_serial_adder: RTL and testbench

Sequential wide adder that computes an N-nibble sum (default 16-bit) by passing operands through a 4-bit ripple-carry add one nibble per clock, least-significant nibble first. The carry is registered between nibbles. It sits between an operand source and a result consumer, using valid/ready handshakes on both sides. It lets wide additions reuse a single 4-bit adder datapath instead of a full-width carry chain.

---
 rtl/nibble_serial_adder.sv | 152 +++++++++++++++
 tb/tb_nibble_serial_adder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder
// Description : Sequential W-bit adder (W = 4*NIBBLES). One 4-bit ripple add
//               per clock, least-significant nibble first, carry registered
//               between nibbles. Valid/ready handshake on both sides.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   in_valid   in   operands a, b, cin presented
//   in_ready   out  block can accept operands (IDLE)
//   a, b       in   W-bit operands
//   cin        in   carry-in to nibble 0
//   out_valid  out  result available (DONE)
//   out_ready  in   consumer accepts result
//   sum        out  registered (a + b + cin) mod 2^W
//   cout       out  carry out of the MSB nibble
//   ovf        out  two's-complement overflow
// ============================================================================
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 ovf
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 2) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q,     state_d;
    logic [IDX_W-1:0] idx_q,       idx_d;
    logic             carry_q,     carry_d;
    logic [W-1:0]     a_q,         a_d;
    logic [W-1:0]     b_q,         b_d;
    logic [W-1:0]     sum_q,       sum_d;
    logic             cout_q,      cout_d;
    logic             ovf_q,       ovf_d;
    logic             out_valid_q, out_valid_d;

    // Shared 4-bit datapath for the current nibble
    logic [3:0] w_nib_a;
    logic [3:0] w_nib_b;
    logic [4:0] w_nib_res;
    logic [3:0] w_low3_res;   // bit 3 = carry into the nibble's top bit

    assign w_nib_a    = a_q[idx_q*4 +: 4];
    assign w_nib_b    = b_q[idx_q*4 +: 4];
    assign w_nib_res  = {1'b0, w_nib_a} + {1'b0, w_nib_b} + {4'b0000, carry_q};
    assign w_low3_res = {1'b0, w_nib_a[2:0]} + {1'b0, w_nib_b[2:0]} + {3'b000, carry_q};

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d[idx_q*4 +: 4] = w_nib_res[3:0];
                carry_d             = w_nib_res[4];
                if (idx_q == C_LAST_IDX) begin
                    // On the MSB nibble the internal bit-3 carry is the carry
                    // into bit W-1, so overflow is that carry XOR carry-out.
                    idx_d       = '0;
                    cout_d      = w_nib_res[4];
                    ovf_d       = w_low3_res[3] ^ w_nib_res[4];
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_serial_adder
// Description : Self-checking bench for nibble_serial_adder. A driver issues
//               operand transactions and pushes the arithmetic expectation
//               into a scoreboard; a monitor pops on every output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        int           acc;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    logic prev_valid = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: plain wide arithmetic on the operands
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input int acc);
        exp_t e;
        logic [W:0] full;
        full  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        e.s   = full[W-1:0];
        e.c   = full[W];
        e.o   = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
        e.acc = acc;
        return e;
    endfunction

    // Monitor: samples mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid && !prev_valid) begin
                if (sbq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_out_valid: actual=1 required=0");
                end else begin
                    chk("latency", 64'(cyc - sbq[0].acc), 64'(NIBBLES));
                end
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_result: actual=%0h required=none", sum);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("sum",  64'(sum),  64'(e.s));
                    chk("cout", 64'(cout), 64'(e.c));
                    chk("ovf",  64'(ovf),  64'(e.o));
                end
            end
            prev_valid = out_valid;
        end
    end

    // Present operands, wait for accept, record expectation. Enters and
    // leaves at #1 after a rising edge.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic ci, input bit hold, output int acc);
        int n;
        a = x; b = y; cin = ci; in_valid = 1'b1;
        n = 0;
        acc = -1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                total++; bad++;
                $display("FAIL accept_timeout: actual=no_accept required=accept");
                in_valid = 1'b0;
                @(posedge clk); #1;
                return;
            end
        end
        @(posedge clk); #1;
        acc = cyc;
        sbq.push_back(model(x, y, ci, acc));
        if (!hold) begin
            in_valid = 1'b0;
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        end
    endtask

    task automatic drain(input bit rnd_ready);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            if (rnd_ready) out_ready = 1'($urandom);
            @(posedge clk); #1;
            n++;
        end
        if (sbq.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout: actual=%0d required=0", sbq.size());
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        int acc1, acc2, n;

        // Reset
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sum",       64'(sum),       64'h0);
        chk("rst_cout",      64'(cout),      64'h0);
        chk("rst_ovf",       64'(ovf),       64'h0);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_in_ready",  64'(in_ready),  64'h1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed arithmetic corners
        out_ready = 1'b1;
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, acc1); drain(1'b0);
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, acc1); drain(1'b0);
        issue(16'h8000, 16'h8000, 1'b0, 1'b0, acc1); drain(1'b0);

        // Operand changes after accept must not matter
        issue(16'h1234, 16'h4321, 1'b1, 1'b0, acc1);
        for (int i = 0; i < 6; i++) begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            @(posedge clk); #1;
        end
        drain(1'b0);

        // Backpressure in DONE with ignored in_valid pulses
        out_ready = 1'b0;
        issue(16'h00FF, 16'h0001, 1'b0, 1'b0, acc1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_reached_done", 64'(out_valid), 64'h1);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom);
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'h1);
            chk("bp_sum",       64'(sum),       64'h0100);
            chk("bp_in_ready",  64'(in_ready),  64'h0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_in_ready",  64'(in_ready),  64'h1);
        chk("bp_release_out_valid", 64'(out_valid), 64'h0);
        chk("bp_sb_empty",          64'(sbq.size()), 64'h0);

        // Reset mid-RUN at idx=2
        issue(16'hAAAA, 16'h5555, 1'b0, 1'b0, acc1);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sbq.delete();
        chk("mrst_sum",       64'(sum),       64'h0);
        chk("mrst_cout",      64'(cout),      64'h0);
        chk("mrst_ovf",       64'(ovf),       64'h0);
        chk("mrst_out_valid", 64'(out_valid), 64'h0);
        chk("mrst_in_ready",  64'(in_ready),  64'h1);
        issue(16'h0001, 16'h0001, 1'b0, 1'b0, acc1); drain(1'b0);

        // Back-to-back with in_valid held high
        out_ready = 1'b1;
        issue(16'h000F, 16'h0001, 1'b0, 1'b1, acc1);
        issue(16'hF000, 16'h1000, 1'b0, 1'b0, acc2);
        chk("b2b_spacing", 64'(acc2 - acc1), 64'(NIBBLES + 2));
        drain(1'b0);

        // Randomized operations with random backpressure
        for (int i = 0; i < 40; i++) begin
            out_ready = 1'b1;
            issue(W'($urandom), W'($urandom), 1'($urandom), 1'b0, acc1);
            drain(1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=timeout required=finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
